board_state_ctrl: RTL and testbench

Game-state writer for the tic-tac-toe display path. It converts debounced push-button levels into cursor moves and mark placements, and maintains the 9-cell board consumed by the VGA renderer. After each placement it runs a sequential 8-line win scan, then alternates players or ends the game in WIN or DRAW. It sits between the button debouncers and the VGA controller, in the same clock domain as the renderer.

---
 rtl/board_state_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_board_state_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_state_ctrl.sv
// Tic-tac-toe game-state writer: button edges -> cursor moves / placements, then a sequential win scan.
// Optional build macro BOARD_CURSOR_WRAP_EN makes the cursor wrap within its row/column instead of saturating.
module board_state_ctrl #(
  parameter int START_CELL = 4
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iLEFT,
  input  logic        iRIGHT,
  input  logic        iUP,
  input  logic        iDOWN,
  input  logic        iPLACE,
  input  logic        iNEW_GAME,
  output logic [17:0] oBOARD,
  output logic [3:0]  oCURSOR,
  output logic        oPLAYER,
  output logic        oBUSY,
  output logic [1:0]  oWINNER,
  output logic [2:0]  oWIN_LINE,
  output logic        oDRAW
);

  localparam logic [1:0] S_PLAY  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_WIN   = 2'd2;
  localparam logic [1:0] S_DRAW  = 2'd3;

  localparam logic [3:0] START = 4'(START_CELL);

`ifdef BOARD_CURSOR_WRAP_EN
  localparam logic WRAP_EN = 1'b1;
`else
  localparam logic WRAP_EN = 1'b0;
`endif

  logic [1:0]  state_q, state_d;
  logic [17:0] board_q, board_d;
  logic [3:0]  cursor_q, cursor_d;
  logic        player_q, player_d;
  logic [3:0]  moves_q, moves_d;
  logic [2:0]  line_q, line_d;
  logic [1:0]  winner_q, winner_d;
  logic [2:0]  win_line_q, win_line_d;
  logic        draw_q, draw_d;
  logic        busy_q, busy_d;
  logic [5:0]  prev_q, prev_d;

  logic [5:0]  btn;
  logic [5:0]  rise;
  logic [3:0]  dir;
  logic        one_dir;
  logic [1:0]  mover;
  logic        line_hit;

  // Cell index of position pos (0..2) within the given win line.
  function automatic logic [3:0] line_cell(input logic [2:0] line, input logic [1:0] pos);
    logic [11:0] c;
    case (line)
      3'd0: c = {4'd0, 4'd1, 4'd2};
      3'd1: c = {4'd3, 4'd4, 4'd5};
      3'd2: c = {4'd6, 4'd7, 4'd8};
      3'd3: c = {4'd0, 4'd3, 4'd6};
      3'd4: c = {4'd1, 4'd4, 4'd7};
      3'd5: c = {4'd2, 4'd5, 4'd8};
      3'd6: c = {4'd0, 4'd4, 4'd8};
      default: c = {4'd2, 4'd4, 4'd6};
    endcase
    case (pos)
      2'd0:    return c[11:8];
      2'd1:    return c[7:4];
      default: return c[3:0];
    endcase
  endfunction

  function automatic logic [1:0] cell_of(input logic [17:0] board, input logic [3:0] idx);
    return board[{idx, 1'b0} +: 2];
  endfunction

  // dir is one-hot {up, down, left, right}.
  function automatic logic [3:0] next_cursor(input logic [3:0] cur, input logic [3:0] dir_oh);
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] nxt;
    row = (cur >= 4'd6) ? 4'd2 : (cur >= 4'd3) ? 4'd1 : 4'd0;
    col = cur - row * 4'd3;
    nxt = cur;
    if (dir_oh[3]) begin
      if (row == 4'd0) nxt = WRAP_EN ? cur + 4'd6 : cur;
      else             nxt = cur - 4'd3;
    end else if (dir_oh[2]) begin
      if (row == 4'd2) nxt = WRAP_EN ? cur - 4'd6 : cur;
      else             nxt = cur + 4'd3;
    end else if (dir_oh[1]) begin
      if (col == 4'd0) nxt = WRAP_EN ? cur + 4'd2 : cur;
      else             nxt = cur - 4'd1;
    end else if (dir_oh[0]) begin
      if (col == 4'd2) nxt = WRAP_EN ? cur - 4'd2 : cur;
      else             nxt = cur + 4'd1;
    end
    return nxt;
  endfunction

  assign btn     = {iNEW_GAME, iPLACE, iUP, iDOWN, iLEFT, iRIGHT};
  assign rise    = btn & ~prev_q;
  assign dir     = rise[3:0];
  assign one_dir = (dir != 4'd0) && ((dir & (dir - 4'd1)) == 4'd0);
  assign mover   = {1'b1, player_q};

  assign line_hit = (cell_of(board_q, line_cell(line_q, 2'd0)) == mover) &&
                    (cell_of(board_q, line_cell(line_q, 2'd1)) == mover) &&
                    (cell_of(board_q, line_cell(line_q, 2'd2)) == mover);

  always_comb begin
    state_d    = state_q;
    board_d    = board_q;
    cursor_d   = cursor_q;
    player_d   = player_q;
    moves_d    = moves_q;
    line_d     = line_q;
    winner_d   = winner_q;
    win_line_d = win_line_q;
    draw_d     = draw_q;
    prev_d     = btn;

    // New game overrides everything; reloading prev with ones swallows buttons still held.
    if (rise[5]) begin
      state_d    = S_PLAY;
      board_d    = '0;
      cursor_d   = START;
      player_d   = 1'b0;
      moves_d    = '0;
      line_d     = '0;
      winner_d   = '0;
      win_line_d = '0;
      draw_d     = 1'b0;
      prev_d     = '1;
    end else begin
      case (state_q)
        S_PLAY: begin
          if (rise[4]) begin
            if (cell_of(board_q, cursor_q) == 2'b00) begin
              board_d[{cursor_q, 1'b0} +: 2] = mover;
              moves_d = moves_q + 4'd1;
              line_d  = '0;
              state_d = S_CHECK;
            end
          end else if (one_dir) begin
            cursor_d = next_cursor(cursor_q, dir);
          end
        end
        S_CHECK: begin
          if (line_hit) begin
            state_d    = S_WIN;
            winner_d   = mover;
            win_line_d = line_q;
          end else if (line_q == 3'd7) begin
            if (moves_q == 4'd9) begin
              state_d = S_DRAW;
              draw_d  = 1'b1;
            end else begin
              player_d = ~player_q;
              state_d  = S_PLAY;
            end
          end else begin
            line_d = line_q + 3'd1;
          end
        end
        default: ;
      endcase
    end

    busy_d = (state_d == S_CHECK);
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q    <= S_PLAY;
      board_q    <= '0;
      cursor_q   <= START;
      player_q   <= 1'b0;
      moves_q    <= '0;
      line_q     <= '0;
      winner_q   <= '0;
      win_line_q <= '0;
      draw_q     <= 1'b0;
      busy_q     <= 1'b0;
      prev_q     <= '1;
    end else begin
      state_q    <= state_d;
      board_q    <= board_d;
      cursor_q   <= cursor_d;
      player_q   <= player_d;
      moves_q    <= moves_d;
      line_q     <= line_d;
      winner_q   <= winner_d;
      win_line_q <= win_line_d;
      draw_q     <= draw_d;
      busy_q     <= busy_d;
      prev_q     <= prev_d;
    end
  end

  assign oBOARD    = board_q;
  assign oCURSOR   = cursor_q;
  assign oPLAYER   = player_q;
  assign oBUSY     = busy_q;
  assign oWINNER   = winner_q;
  assign oWIN_LINE = win_line_q;
  assign oDRAW     = draw_q;

endmodule

// File: tb/tb_board_state_ctrl.sv
// Bench for board_state_ctrl: directed scenarios plus a random run against a game-level model.
module tb_board_state_ctrl;

  logic        iCLK = 1'b0;
  logic        iRST, iLEFT, iRIGHT, iUP, iDOWN, iPLACE, iNEW_GAME;
  logic [17:0] oBOARD;
  logic [3:0]  oCURSOR;
  logic        oPLAYER, oBUSY, oDRAW;
  logic [1:0]  oWINNER;
  logic [2:0]  oWIN_LINE;

  board_state_ctrl #(.START_CELL(4)) dut (
    .iCLK(iCLK), .iRST(iRST), .iLEFT(iLEFT), .iRIGHT(iRIGHT), .iUP(iUP), .iDOWN(iDOWN),
    .iPLACE(iPLACE), .iNEW_GAME(iNEW_GAME), .oBOARD(oBOARD), .oCURSOR(oCURSOR),
    .oPLAYER(oPLAYER), .oBUSY(oBUSY), .oWINNER(oWINNER), .oWIN_LINE(oWIN_LINE), .oDRAW(oDRAW)
  );

  always #5 iCLK = ~iCLK;

`ifdef BOARD_CURSOR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  localparam logic [6:0] B_RST = 7'h40, B_NEW = 7'h20, B_PLACE = 7'h10;
  localparam logic [6:0] B_UP = 7'h08, B_DOWN = 7'h04, B_LEFT = 7'h02, B_RIGHT = 7'h01;

  int n_checks = 0;
  int n_fail   = 0;

  // Game-level model: mode 0 play, 1 scanning, 2 won, 3 drawn.
  int m_board [9];
  int m_cur = 4, m_player = 0, m_moves = 0, m_mode = 0, m_cnt = 0, m_pend = -1;
  int m_winner = 0, m_winline = 0, m_draw = 0;
  logic [5:0] m_prev = '1;
  int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6}, '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  task automatic model_clear();
    for (int i = 0; i < 9; i++) m_board[i] = 0;
    m_cur = 4; m_player = 0; m_moves = 0; m_mode = 0; m_cnt = 0; m_pend = -1;
    m_winner = 0; m_winline = 0; m_draw = 0; m_prev = '1;
  endtask

  task automatic model_update(input logic [6:0] v);
    logic [5:0] e;
    int code, ndir, r, c;
    if (v[6]) begin
      model_clear();
      return;
    end
    e = v[5:0] & ~m_prev;
    m_prev = v[5:0];
    if (e[5]) begin
      model_clear();
    end else if (m_mode == 0) begin
      if (e[4]) begin
        if (m_board[m_cur] == 0) begin
          code = (m_player != 0) ? 3 : 2;
          m_board[m_cur] = code;
          m_moves++;
          m_pend = -1;
          for (int l = 0; l < 8; l++)
            if (m_pend < 0 && m_board[lines[l][0]] == code && m_board[lines[l][1]] == code &&
                m_board[lines[l][2]] == code) m_pend = l;
          m_cnt  = (m_pend >= 0) ? m_pend + 1 : 8;
          m_mode = 1;
        end
      end else begin
        ndir = int'(e[3]) + int'(e[2]) + int'(e[1]) + int'(e[0]);
        if (ndir == 1) begin
          r = m_cur / 3;
          c = m_cur % 3;
          if (e[3]) r = (r > 0) ? r - 1 : (WRAP ? 2 : r);
          if (e[2]) r = (r < 2) ? r + 1 : (WRAP ? 0 : r);
          if (e[1]) c = (c > 0) ? c - 1 : (WRAP ? 2 : c);
          if (e[0]) c = (c < 2) ? c + 1 : (WRAP ? 0 : c);
          m_cur = r * 3 + c;
        end
      end
    end else if (m_mode == 1) begin
      m_cnt--;
      if (m_cnt == 0) begin
        if (m_pend >= 0) begin
          m_mode = 2; m_winner = (m_player != 0) ? 3 : 2; m_winline = m_pend;
        end else if (m_moves == 9) begin
          m_mode = 3; m_draw = 1;
        end else begin
          m_player ^= 1; m_mode = 0;
        end
      end
    end
  endtask

  function automatic logic [17:0] model_bits();
    logic [17:0] b;
    for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(m_board[i]);
    return b;
  endfunction

  task automatic step(input logic [6:0] v);
    {iRST, iNEW_GAME, iPLACE, iUP, iDOWN, iLEFT, iRIGHT} = v;
    @(posedge iCLK);
    model_update(v);
    #1;
  endtask

  task automatic goto(input int target);
    for (int i = 0; i < 8 && m_cur != target; i++) begin
      int r, c, tr, tc;
      logic [6:0] b;
      r = m_cur / 3; c = m_cur % 3; tr = target / 3; tc = target % 3;
      if (tr < r) b = B_UP;
      else if (tr > r) b = B_DOWN;
      else if (tc < c) b = B_LEFT;
      else b = B_RIGHT;
      step(b);
      step(7'h00);
    end
    n_checks++;
    if (oCURSOR !== 4'(target)) begin
      n_fail++; $display("FAIL goto cursor=%0d required=%0d", oCURSOR, target);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 12 && m_mode == 1; i++) step(7'h00);
  endtask

  task automatic place_at(input int target);
    goto(target);
    step(B_PLACE);
    step(7'h00);
    wait_idle();
  endtask

  task automatic test_reset();
    int busy_cycles;
    step(B_RST | B_PLACE);
    step(B_RST | B_PLACE);
    n_checks++;
    if ({oBOARD, oCURSOR, oPLAYER, oBUSY, oWINNER, oWIN_LINE, oDRAW} !== {18'h0, 4'd4, 1'b0, 1'b0, 2'b00, 3'd0, 1'b0}) begin
      n_fail++; $display("FAIL reset_values board=%h cur=%0d pl=%b busy=%b win=%b line=%0d draw=%b required 0/4/0/0/0/0/0",
                         oBOARD, oCURSOR, oPLAYER, oBUSY, oWINNER, oWIN_LINE, oDRAW);
    end
    step(B_PLACE);
    n_checks++;
    if (oBOARD !== 18'h0 || oBUSY !== 1'b0) begin
      n_fail++; $display("FAIL held_place_through_reset board=%h busy=%b required 0/0", oBOARD, oBUSY);
    end
    step(7'h00);
    step(B_PLACE);
    n_checks++;
    if (oBOARD !== 18'h00200 || oBUSY !== 1'b1) begin
      n_fail++; $display("FAIL first_place board=%h busy=%b required 00200/1", oBOARD, oBUSY);
    end
    busy_cycles = 1;
    for (int i = 0; i < 20 && oBUSY; i++) begin
      step(7'h00);
      if (oBUSY) busy_cycles++;
    end
    n_checks++;
    if (busy_cycles != 8 || oPLAYER !== 1'b1) begin
      n_fail++; $display("FAIL busy_len busy_cycles=%0d player=%b required 8/1", busy_cycles, oPLAYER);
    end
  endtask

  task automatic test_occupied();
    step(B_PLACE);
    n_checks++;
    if (oBOARD !== 18'h00200 || oBUSY !== 1'b0 || oPLAYER !== 1'b1) begin
      n_fail++; $display("FAIL occupied_place board=%h busy=%b player=%b required 00200/0/1", oBOARD, oBUSY, oPLAYER);
    end
    step(7'h00);
    step(7'h00);
    n_checks++;
    if (oBUSY !== 1'b0 || oBOARD !== 18'h00200) begin
      n_fail++; $display("FAIL occupied_idle busy=%b board=%h required 0/00200", oBUSY, oBOARD);
    end
  endtask

  task automatic test_win();
    step(B_NEW);
    step(7'h00);
    place_at(0); place_at(3); place_at(1); place_at(4);
    goto(2);
    step(B_PLACE);
    n_checks++;
    if (oBOARD !== 18'h003EA || oBUSY !== 1'b1 || oWINNER !== 2'b00) begin
      n_fail++; $display("FAIL win_place board=%h busy=%b winner=%b required 003ea/1/00", oBOARD, oBUSY, oWINNER);
    end
    step(7'h00);
    n_checks++;
    if (oWINNER !== 2'b10 || oWIN_LINE !== 3'd0 || oBUSY !== 1'b0 || oPLAYER !== 1'b0) begin
      n_fail++; $display("FAIL win_result winner=%b line=%0d busy=%b player=%b required 10/0/0/0",
                         oWINNER, oWIN_LINE, oBUSY, oPLAYER);
    end
    step(B_PLACE | B_LEFT);
    step(7'h00);
    step(B_DOWN);
    n_checks++;
    if (oBOARD !== 18'h003EA || oCURSOR !== 4'd2 || oWINNER !== 2'b10 || oBUSY !== 1'b0) begin
      n_fail++; $display("FAIL win_frozen board=%h cur=%0d winner=%b busy=%b required 003ea/2/10/0",
                         oBOARD, oCURSOR, oWINNER, oBUSY);
    end
    step(7'h00);
  endtask

  task automatic test_draw();
    step(B_NEW);
    step(7'h00);
    place_at(0); place_at(1); place_at(2); place_at(4);
    place_at(3); place_at(5); place_at(7); place_at(6);
    goto(8);
    step(B_PLACE);
    n_checks++;
    if (oBOARD !== 18'h2BFAE || oBUSY !== 1'b1) begin
      n_fail++; $display("FAIL draw_place board=%h busy=%b required 2bfae/1", oBOARD, oBUSY);
    end
    for (int i = 0; i < 7; i++) step(7'h00);
    n_checks++;
    if (oBUSY !== 1'b1 || oDRAW !== 1'b0) begin
      n_fail++; $display("FAIL draw_early busy=%b draw=%b required 1/0", oBUSY, oDRAW);
    end
    step(7'h00);
    n_checks++;
    if (oDRAW !== 1'b1 || oBUSY !== 1'b0 || oWINNER !== 2'b00) begin
      n_fail++; $display("FAIL draw_result draw=%b busy=%b winner=%b required 1/0/00", oDRAW, oBUSY, oWINNER);
    end
    step(B_NEW);
    n_checks++;
    if (oBOARD !== 18'h0 || oCURSOR !== 4'd4 || oPLAYER !== 1'b0 || oDRAW !== 1'b0 || oBUSY !== 1'b0) begin
      n_fail++; $display("FAIL draw_newgame board=%h cur=%0d player=%b draw=%b busy=%b required 0/4/0/0/0",
                         oBOARD, oCURSOR, oPLAYER, oDRAW, oBUSY);
    end
    step(7'h00);
  endtask

  task automatic test_cursor();
    logic [3:0] exp_cur;
    step(B_NEW);
    step(7'h00);
    goto(3);
    step(B_LEFT);
    exp_cur = WRAP ? 4'd5 : 4'd3;
    n_checks++;
    if (oCURSOR !== exp_cur) begin
      n_fail++; $display("FAIL cursor_left_edge cur=%0d required=%0d", oCURSOR, exp_cur);
    end
    step(7'h00);
    step(B_UP | B_RIGHT);
    n_checks++;
    if (oCURSOR !== exp_cur) begin
      n_fail++; $display("FAIL cursor_two_dirs cur=%0d required=%0d", oCURSOR, exp_cur);
    end
    step(7'h00);
    goto(2);
    step(B_UP);
    exp_cur = WRAP ? 4'd8 : 4'd2;
    n_checks++;
    if (oCURSOR !== exp_cur) begin
      n_fail++; $display("FAIL cursor_up_edge cur=%0d required=%0d", oCURSOR, exp_cur);
    end
    step(7'h00);
  endtask

  task automatic test_newgame_mid_check();
    step(B_NEW);
    step(7'h00);
    goto(4);
    step(B_PLACE);
    n_checks++;
    if (oBUSY !== 1'b1 || oBOARD !== 18'h00200) begin
      n_fail++; $display("FAIL midcheck_place busy=%b board=%h required 1/00200", oBUSY, oBOARD);
    end
    step(7'h00); step(7'h00); step(7'h00);
    step(B_NEW | B_PLACE);
    n_checks++;
    if (oBOARD !== 18'h0 || oBUSY !== 1'b0 || oPLAYER !== 1'b0) begin
      n_fail++; $display("FAIL midcheck_newgame board=%h busy=%b player=%b required 0/0/0", oBOARD, oBUSY, oPLAYER);
    end
    step(7'h00);
    step(7'h00);
    n_checks++;
    if (oBOARD !== 18'h0 || oBUSY !== 1'b0) begin
      n_fail++; $display("FAIL midcheck_after board=%h busy=%b required 0/0", oBOARD, oBUSY);
    end
  endtask

  task automatic test_random();
    logic [6:0] v;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      v[6] = ($urandom_range(0, 499) == 0);
      v[5] = ($urandom_range(0, 79) == 0);
      v[4] = ($urandom_range(0, 2) == 0);
      for (int b = 0; b < 4; b++) v[b] = ($urandom_range(0, 4) == 0);
      step(v);
      n_checks++;
      if (oBOARD !== model_bits()) begin
        n_fail++; $display("FAIL rand_board cyc=%0d got=%h exp=%h", cyc, oBOARD, model_bits());
      end
      n_checks++;
      if (oCURSOR !== 4'(m_cur)) begin
        n_fail++; $display("FAIL rand_cursor cyc=%0d got=%0d exp=%0d", cyc, oCURSOR, m_cur);
      end
      n_checks++;
      if (oPLAYER !== 1'(m_player) || oBUSY !== (m_mode == 1)) begin
        n_fail++; $display("FAIL rand_player_busy cyc=%0d got=%b/%b exp=%0d/%0d", cyc, oPLAYER, oBUSY, m_player, m_mode == 1);
      end
      n_checks++;
      if (oWINNER !== 2'(m_winner) || oWIN_LINE !== 3'(m_winline) || oDRAW !== 1'(m_draw)) begin
        n_fail++; $display("FAIL rand_result cyc=%0d got=%b/%0d/%b exp=%0d/%0d/%0d",
                           cyc, oWINNER, oWIN_LINE, oDRAW, m_winner, m_winline, m_draw);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 9; i++) m_board[i] = 0;
    test_reset();
    test_occupied();
    test_win();
    test_draw();
    test_cursor();
    test_newgame_mid_check();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
